// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared types and helpers for the CPU trace monitor.
// Holds state encoding, entry layout offsets/width and signature seed.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_HALTED  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  localparam logic [15:0] SIG_SEED = 16'hFFFF;

  localparam int FLAGS_W = 4;

  // Entry = {pc, flags, wb_en, wb_addr, wb_data}, wb_data at bit 0.
  function automatic int off_wb_addr(int data_w);
    return data_w;
  endfunction

  function automatic int off_wb_en(int data_w, int raddr_w);
    return data_w + raddr_w;
  endfunction

  function automatic int off_flags(int data_w, int raddr_w);
    return data_w + raddr_w + 1;
  endfunction

  function automatic int off_pc(int data_w, int raddr_w);
    return data_w + raddr_w + 1 + FLAGS_W;
  endfunction

  function automatic int entry_w(int pc_w, int raddr_w, int data_w);
    return pc_w + FLAGS_W + 1 + raddr_w + data_w;
  endfunction

endpackage

// File: rtl/cpu_trace_monitor_ram.sv
// trace_ram: DEPTH x WIDTH storage, sync write port, sync read port.
// Ports: clk, we/waddr/wdata write side, re/raddr/rdata read side.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read-before-write: a same-edge write to raddr is not visible.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: retirement trace buffer with halt/timeout detect.
// Ports: clk, reset(n), trace_en, pc/pc_en/done/flags/wb_*, rd_req/rd_idx
// in; rd_valid/rd_data, entry_count, wrapped, halted, timeout,
// cycle_count out; sig out when TRACE_SIGNATURE_EN is defined.
module cpu_trace_monitor
  import cpu_trace_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int PC_W           = 16,
  parameter int RADDR_W        = 3,
  parameter int DEPTH          = 16,
  parameter int HALT_REPEAT    = 4,
  parameter int TIMEOUT_CYCLES = 300,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1,
  localparam int ENTRY_W = entry_w(PC_W, RADDR_W, DATA_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trace_en,
  input  logic [PC_W-1:0]    pc,
  input  logic               pc_en,
  input  logic               done,
  input  logic [3:0]         flags,
  input  logic               wb_en,
  input  logic [RADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               rd_req,
  input  logic [PTR_W-1:0]   rd_idx,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [CNT_W-1:0]   entry_count,
  output logic               wrapped,
  output logic               halted,
  output logic               timeout,
  output logic [31:0]        cycle_count
`ifdef TRACE_SIGNATURE_EN
  ,
  output logic [15:0]        sig
`endif
);

  localparam int RW = $clog2(HALT_REPEAT + 1);

  state_t             state;
  logic [PTR_W-1:0]   wr_ptr;
  logic [RW-1:0]      rep_cnt;
  logic [PC_W-1:0]    prev_pc;
  logic               rd_hit;

  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] ram_q;
  logic [PTR_W-1:0]   rd_phys;
  logic [RW-1:0]      rep_nxt;
  logic               run;
  logic               cap;
  logic               full;
  logic               same_pc;
  logic               halt_hit;
  logic               tmo_hit;

  assign entry = {pc, flags, wb_en, wb_addr, wb_data};
  assign run   = state == S_RUN;
  assign cap   = run && pc_en;
  assign full  = entry_count == CNT_W'(DEPTH);

  // rep_cnt == 0 means no retirement seen yet, so nothing to compare.
  assign same_pc = (rep_cnt != '0) && (pc == prev_pc);
  assign rep_nxt = same_pc ? rep_cnt + 1'b1 : RW'(1);

  assign halt_hit = run && (done ||
    (pc_en && rep_nxt == RW'(HALT_REPEAT)));
  assign tmo_hit = run && !halt_hit &&
    cycle_count == 32'(TIMEOUT_CYCLES - 1);

  // Oldest entry sits entry_count slots behind the write pointer.
  assign rd_phys = wr_ptr - entry_count[PTR_W-1:0] + rd_idx;

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (cap),
    .waddr (wr_ptr),
    .wdata (entry),
    .re    (rd_req),
    .raddr (rd_phys),
    .rdata (ram_q)
  );

  assign rd_data = rd_hit ? ram_q : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      entry_count <= '0;
      rep_cnt     <= '0;
      prev_pc     <= '0;
      wrapped     <= 1'b0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      rd_valid    <= 1'b0;
      rd_hit      <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      rd_hit   <= rd_req &&
        (CNT_W'(rd_idx) < entry_count);

      if (run && cycle_count != '1)
        cycle_count <= cycle_count + 1'b1;

      if (cap) begin
        wr_ptr  <= wr_ptr + 1'b1;
        rep_cnt <= rep_nxt;
        prev_pc <= pc;
        if (full) wrapped <= 1'b1;
        else entry_count <= entry_count + 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          if (trace_en) state <= S_RUN;
        end
        S_RUN: begin
          if (halt_hit) begin
            state  <= S_HALTED;
            halted <= 1'b1;
          end else if (tmo_hit) begin
            state   <= S_TIMEOUT;
            timeout <= 1'b1;
          end else if (!trace_en) begin
            state <= S_IDLE;
          end
        end
        S_HALTED, S_TIMEOUT: ;
      endcase
    end
  end

`ifdef TRACE_SIGNATURE_EN
  // Captures only happen in RUN, so sig freezes once terminal.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sig <= SIG_SEED;
    else if (cap)
      sig <= {sig[14:0], sig[15]} ^ entry[15:0];
  end
`endif

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// tb_cpu_trace_monitor: directed scoreboard bench for cpu_trace_monitor.
// Read responses are queued at issue and checked by a monitor process.
module tb_cpu_trace_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        trace_en = 1'b0;
  logic [15:0] pc = '0;
  logic        pc_en = 1'b0;
  logic        done = 1'b0;
  logic [3:0]  flags = '0;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_addr = '0;
  logic [7:0]  wb_data = '0;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_idx = '0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [4:0]  entry_count;
  logic        wrapped;
  logic        halted;
  logic        timeout;
  logic [31:0] cycle_count;
`ifdef TRACE_SIGNATURE_EN
  logic [15:0] sig;
  logic [15:0] sig_exp;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] expq[$];
  logic [31:0] mon_e;
  logic        req_q = 1'b0;

  always #5 clk = ~clk;

  cpu_trace_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .trace_en    (trace_en),
    .pc          (pc),
    .pc_en       (pc_en),
    .done        (done),
    .flags       (flags),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .rd_req      (rd_req),
    .rd_idx      (rd_idx),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .entry_count (entry_count),
    .wrapped     (wrapped),
    .halted      (halted),
    .timeout     (timeout),
    .cycle_count (cycle_count)
`ifdef TRACE_SIGNATURE_EN
    ,
    .sig         (sig)
`endif
  );

  // A request should produce exactly one valid cycle, one edge later.
  always @(posedge clk or negedge reset) begin
    if (!reset) req_q <= 1'b0;
    else req_q <= rd_req;
  end

  always @(negedge clk) begin
    if (rd_valid || req_q) begin
      checks++;
      if (rd_valid !== req_q) begin
        errors++;
        $display("FAIL rd_valid got %b want %b", rd_valid, req_q);
      end
      if (req_q) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL rd_data got %h want <none queued>", rd_data);
        end else begin
          mon_e = expq.pop_front();
          if (rd_data !== mon_e) begin
            errors++;
            $display("FAIL rd_data got %h want %h", rd_data, mon_e);
          end
        end
      end
    end
  end

  function automatic logic [31:0] ent(
    input logic [15:0] p, input logic [3:0] f, input logic we,
    input logic [2:0] a, input logic [7:0] d);
    return {p, f, we, a, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic retire(input logic [15:0] p, input logic [7:0] d);
    pc = p;
    flags = p[3:0];
    wb_en = 1'b1;
    wb_addr = p[2:0];
    wb_data = d;
    pc_en = 1'b1;
    step();
    pc_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx, input logic [31:0] exp);
    rd_idx = idx;
    rd_req = 1'b1;
    expq.push_back(exp);
    step();
    rd_req = 1'b0;
  endtask

  task automatic do_reset();
    step();
    trace_en = 1'b0;
    pc_en = 1'b0;
    done = 1'b0;
    rd_req = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

`ifdef TRACE_SIGNATURE_EN
  function automatic logic [15:0] sig_step(input logic [15:0] s,
                                           input logic [31:0] e);
    return {s[14:0], s[15]} ^ e[15:0];
  endfunction
`endif

  initial begin
    step();
    reset = 1'b1;
    step();
    chk("rst_count", 32'(entry_count), 32'd0);
    chk("rst_flags", {29'd0, wrapped, halted, timeout}, 32'd0);
    chk("rst_cycles", cycle_count, 32'd0);
    chk("rst_rd", {rd_data[30:0], rd_valid}, 32'd0);

    // Five retirements then indexed reads incl. out of range.
    trace_en = 1'b1;
    step();
    for (int i = 0; i < 5; i++) retire(16'(i), 8'(8'h10 + i));
    chk("t1_count", 32'(entry_count), 32'd5);
    chk("t1_wrapped", 32'(wrapped), 32'd0);
    chk("t1_cycles", cycle_count, 32'd5);
    rd(4'd0, ent(16'd0, 4'd0, 1'b1, 3'd0, 8'h10));
    rd(4'd4, ent(16'd4, 4'd4, 1'b1, 3'd4, 8'h14));
    rd(4'd5, 32'd0);
    trace_en = 1'b0;
    step();
    retire(16'd9, 8'd9);
    chk("idle_count", 32'(entry_count), 32'd5);
    chk("idle_cycles", cycle_count, 32'd9);

    // Wrap: 20 retirements into 16 slots.
    do_reset();
    trace_en = 1'b1;
    step();
    for (int i = 0; i < 16; i++) retire(16'(i), 8'(i));
    chk("t2_full_count", 32'(entry_count), 32'd16);
    chk("t2_full_wrapped", 32'(wrapped), 32'd0);
    for (int i = 16; i < 20; i++) retire(16'(i), 8'(i));
    chk("t2_count", 32'(entry_count), 32'd16);
    chk("t2_wrapped", 32'(wrapped), 32'd1);
    rd(4'd0, ent(16'd4, 4'd4, 1'b1, 3'd4, 8'd4));
    rd(4'd15, ent(16'd19, 4'd3, 1'b1, 3'd3, 8'd19));
    // Read of the slot being overwritten returns the old entry.
    rd_idx = 4'd0;
    rd_req = 1'b1;
    expq.push_back(ent(16'd4, 4'd4, 1'b1, 3'd4, 8'd4));
    retire(16'd20, 8'd20);
    rd_req = 1'b0;
    rd(4'd0, ent(16'd5, 4'd5, 1'b1, 3'd5, 8'd5));
    rd(4'd15, ent(16'd20, 4'd4, 1'b1, 3'd4, 8'd20));

    // Branch-to-self halt after four equal PCs.
    do_reset();
    trace_en = 1'b1;
    step();
    for (int i = 0; i < 3; i++) retire(16'd7, 8'd7);
    chk("t3_pre_halt", 32'(halted), 32'd0);
    retire(16'd7, 8'd7);
    chk("t3_halted", 32'(halted), 32'd1);
    chk("t3_count", 32'(entry_count), 32'd4);
    retire(16'd8, 8'd8);
    retire(16'd9, 8'd9);
    chk("t3_frozen", 32'(entry_count), 32'd4);
    rd(4'd3, ent(16'd7, 4'd7, 1'b1, 3'd7, 8'd7));

    // A differing PC restarts the repeat count.
    do_reset();
    trace_en = 1'b1;
    step();
    for (int i = 0; i < 3; i++) retire(16'd7, 8'd7);
    for (int i = 0; i < 3; i++) retire(16'd5, 8'd5);
    chk("t3b_no_halt", 32'(halted), 32'd0);
    retire(16'd5, 8'd5);
    chk("t3b_halted", 32'(halted), 32'd1);
    chk("t3b_count", 32'(entry_count), 32'd7);

    // Timeout after exactly 300 RUN cycles.
    do_reset();
    trace_en = 1'b1;
    step();
    for (int i = 0; i < 299; i++) retire(16'(i), 8'(i));
    chk("t4_pre_tmo", 32'(timeout), 32'd0);
    retire(16'd299, 8'd43);
    chk("t4_timeout", 32'(timeout), 32'd1);
    chk("t4_halted", 32'(halted), 32'd0);
    chk("t4_cycles", cycle_count, 32'd300);
    for (int i = 0; i < 5; i++) retire(16'(400 + i), 8'(i));
    chk("t4_frozen", cycle_count, 32'd300);
    chk("t4_count", 32'(entry_count), 32'd16);

    // done on the would-be timeout cycle: halt wins.
    do_reset();
    trace_en = 1'b1;
    step();
    repeat (299) step();
    chk("t5_cycles", cycle_count, 32'd299);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("t5_halted", 32'(halted), 32'd1);
    chk("t5_timeout", 32'(timeout), 32'd0);
    repeat (3) step();
    chk("t5_frozen", cycle_count, 32'd300);

    // Asynchronous reset mid-RUN clears outputs without a clock.
    do_reset();
    trace_en = 1'b1;
    step();
    for (int i = 0; i < 3; i++) retire(16'(i), 8'(i));
    chk("t6_pre_count", 32'(entry_count), 32'd3);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_count", 32'(entry_count), 32'd0);
    chk("t6_cycles", cycle_count, 32'd0);
    chk("t6_flags", {29'd0, wrapped, halted, timeout}, 32'd0);
    step();
    reset = 1'b1;

`ifdef TRACE_SIGNATURE_EN
    do_reset();
    chk("sig_seed", 32'(sig), 32'h0000FFFF);
    trace_en = 1'b1;
    step();
    pc = 16'd0;
    flags = 4'd0;
    wb_en = 1'b0;
    wb_addr = 3'd0;
    wb_data = 8'd1;
    pc_en = 1'b1;
    step();
    pc_en = 1'b0;
    chk("sig_one", 32'(sig), 32'h0000FFFE);
    sig_exp = 16'hFFFE;
    for (int i = 0; i < 4; i++) begin
      retire(16'd3, 8'd3);
      sig_exp = sig_step(sig_exp, ent(16'd3, 4'd3, 1'b1, 3'd3, 8'd3));
    end
    chk("sig_halted", 32'(halted), 32'd1);
    chk("sig_run", 32'(sig), 32'(sig_exp));
    retire(16'd9, 8'd9);
    chk("sig_frozen", 32'(sig), 32'(sig_exp));
`endif

    repeat (3) step();
    chk("rd_queue_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
